// File: rtl/spi_keycode_slave.sv
// SPI mode-0 responder that lets an external master write the game keycode
// and read back score/status; all SPI pins are oversampled in the Clk domain.
`timescale 1ns / 1ps

module spi_keycode_slave #(
  parameter logic [7:0] ID_VALUE = 8'h62
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  input  logic [9:0] score,
  output logic       MISO,
  output logic       MISO_oe,
  output logic [7:0] keycode,
  output logic       keycode_valid
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  // Synchronizer chains: [0] = first flop, [1] = synchronized value, [2] = previous.
  logic [2:0] sclk_sync_q;
  logic [2:0] ss_sync_q;
  logic [1:0] mosi_sync_q;
  logic       warm_q, armed_q;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_q, wr_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] keycode_q, keycode_d;
  logic [7:0] scratch_q, scratch_d;
  logic       kv_q, kv_d;

  logic       ss_fall, ss_rise, active, sclk_rise, sclk_fall, byte_done;
  logic [7:0] rx_next;

  function automatic logic [7:0] reg_read(input logic [6:0] a);
    case (a)
      7'h00:   return keycode_q;
      7'h01:   return score[7:0];
      7'h02:   return {6'b0, score[9:8]};
      7'h03:   return ID_VALUE;
      7'h04:   return scratch_q;
      default: return 8'h00;
    endcase
  endfunction

  // A frame may only start after SS_n has been seen high since reset, so a
  // frame already in progress when reset is released is ignored.
  assign ss_fall   = armed_q & ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
  assign active    = ~ss_sync_q[1] & (state_q != IDLE);
  assign sclk_rise = active & sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = active & ~sclk_sync_q[1] & sclk_sync_q[2];
  assign rx_next   = {rx_q[6:0], mosi_sync_q[1]};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    keycode_d = keycode_q;
    scratch_d = scratch_q;
    kv_d      = 1'b0;

    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done && state_q == CMD) begin
              state_d = DATA;
              wr_d    = rx_next[7];
              addr_d  = rx_next[6:0];
              tx_d    = reg_read(rx_next[6:0]);
            end else if (byte_done) begin
              if (wr_q && addr_q == 7'h00) begin
                keycode_d = rx_next;
                kv_d      = 1'b1;
              end else if (wr_q && addr_q == 7'h04) begin
                scratch_d = rx_next;
              end
              addr_d = addr_q + 7'd1;
              tx_d   = reg_read(addr_q + 7'd1);
            end
          end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            // The fall right after a load keeps the MSB stable for the next rise.
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      warm_q      <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      wr_q        <= 1'b0;
      addr_q      <= 7'h00;
      keycode_q   <= 8'h00;
      scratch_q   <= 8'h00;
      kv_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      warm_q      <= 1'b1;
      armed_q     <= armed_q | (warm_q & ss_sync_q[0]);
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      keycode_q   <= keycode_d;
      scratch_q   <= scratch_d;
      kv_q        <= kv_d;
    end
  end

  assign MISO          = tx_q[7];
  assign MISO_oe       = ~ss_sync_q[1];
  assign keycode       = keycode_q;
  assign keycode_valid = kv_q;

endmodule

// File: tb/tb_spi_keycode_slave.sv
// Self-checking bench for spi_keycode_slave: directed frames from the test
// plan plus random frames, checked against a frame-level register model.
`timescale 1ns / 1ps

module tb_spi_keycode_slave;

  localparam int HALF = 5;  // SCLK half period in Clk cycles

  logic       Clk = 1'b0;
  logic       Reset_n, SCLK, SS_n, MOSI;
  logic [9:0] score;
  logic       MISO, MISO_oe, keycode_valid;
  logic [7:0] keycode;

  spi_keycode_slave #(.ID_VALUE(8'h62)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .score(score), .MISO(MISO), .MISO_oe(MISO_oe), .keycode(keycode),
    .keycode_valid(keycode_valid)
  );

  initial forever #10 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level model of the register file (used for read-back values).
  logic [7:0] m_key, m_scr;

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'h00:   return m_key;
      7'h01:   return score[7:0];
      7'h02:   return {6'b0, score[9:8]};
      7'h03:   return 8'h62;
      7'h04:   return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  // Cycle-level expectations: keycode lands 3 Clk edges after the final SCLK
  // rise of a keycode write; MISO_oe follows SS_n two Clk edges late.
  int         cyc = 0;
  int         kc_req_cyc = -100;
  logic [7:0] kc_req_val = 8'h00;
  logic [7:0] exp_keycode = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_oe = 1'b0;
  logic [1:0] ss_hist = 2'b11;

  initial forever begin
    @(posedge Clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    if (!Reset_n) begin
      exp_keycode = 8'h00;
      ss_hist     = 2'b11;
    end else begin
      ss_hist = {ss_hist[0], SS_n};
      if (cyc == kc_req_cyc + 3) begin
        exp_keycode = kc_req_val;
        exp_valid   = 1'b1;
      end
    end
    exp_oe = ~ss_hist[1];
  end

  initial forever begin
    @(negedge Clk);
    if (!Reset_n) begin
      check("rst_keycode", 32'(keycode), 32'h00);
      check("rst_keycode_valid", 32'(keycode_valid), 32'h0);
      check("rst_miso", 32'(MISO), 32'h0);
      check("rst_miso_oe", 32'(MISO_oe), 32'h0);
    end else begin
      check("keycode", 32'(keycode), 32'(exp_keycode));
      check("keycode_valid", 32'(keycode_valid), 32'(exp_valid));
      check("miso_oe", 32'(MISO_oe), 32'(exp_oe));
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  // Clocks n bits of v (MSB first); MISO is sampled just before each rise.
  task automatic clock_bits(input logic [7:0] v, input int n, input logic kc, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      MOSI = v[7-i];
      wait_clk(HALF);
      got[7-i] = MISO;
      SCLK = 1'b1;
      if (kc && i == 7) begin
        kc_req_val = v;
        kc_req_cyc = cyc;
      end
      wait_clk(HALF);
      SCLK = 1'b0;
    end
  endtask

  logic [7:0] f_tx[8];
  logic [7:0] f_rx[8];
  int         f_len, f_abort;

  task automatic run_frame();
    logic       w;
    logic [6:0] addr;
    logic [7:0] exp_b, got;
    int         nb;
    w = 1'b0;
    addr = 7'h00;
    SS_n = 1'b0;
    wait_clk(4);
    for (int b = 0; b < f_len; b++) begin
      nb = (b == f_len - 1 && f_abort > 0) ? f_abort : 8;
      exp_b = (b == 0) ? 8'h00 : model_read(addr);
      clock_bits(f_tx[b], nb, (b > 0) && w && (addr == 7'h00), got);
      f_rx[b] = got;
      if (nb == 8) begin
        check($sformatf("miso_byte%0d_cmd%02h", b, f_tx[0]), 32'(got), 32'(exp_b));
        if (b == 0) begin
          w    = f_tx[0][7];
          addr = f_tx[0][6:0];
        end else begin
          if (w && addr == 7'h00) m_key = f_tx[b];
          if (w && addr == 7'h04) m_scr = f_tx[b];
          addr = addr + 7'd1;
        end
      end
    end
    wait_clk(HALF);
    SS_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int len, input int abort_bits);
    f_tx[0] = b0;
    f_tx[1] = b1;
    f_tx[2] = b2;
    f_len   = len;
    f_abort = abort_bits;
    run_frame();
  endtask

  task automatic model_reset();
    m_key = 8'h00;
    m_scr = 8'h00;
    kc_req_cyc = -100;
  endtask

  initial begin
    logic [7:0] junk;
    int         r;
    logic [6:0] a;
    Reset_n = 1'b0;
    SCLK = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
    score = 10'h000;
    model_reset();
    wait_clk(3);
    check("reset_keycode", 32'(keycode), 32'h00);
    check("reset_miso_oe", 32'(MISO_oe), 32'h0);
    Reset_n = 1'b1;
    wait_clk(4);

    // Keycode write, twice so the second read-back shows the first write.
    frame(8'h80, 8'h04, 8'h00, 2, 0);
    check("kw1_readback", 32'(f_rx[1]), 32'h00);
    check("kw1_keycode", 32'(keycode), 32'h04);
    frame(8'h80, 8'h04, 8'h00, 2, 0);
    check("kw2_readback", 32'(f_rx[1]), 32'h04);

    frame(8'h03, 8'hFF, 8'h00, 2, 0);
    check("id_read", 32'(f_rx[1]), 32'h62);
    check("id_keycode_kept", 32'(keycode), 32'h04);

    score = 10'h2A5;
    frame(8'h01, 8'h00, 8'h00, 3, 0);
    check("score_lo", 32'(f_rx[1]), 32'hA5);
    check("score_hi", 32'(f_rx[2]), 32'h02);

    frame(8'h83, 8'h11, 8'h00, 2, 0);
    frame(8'h03, 8'h00, 8'h00, 2, 0);
    check("ro_write_ignored", 32'(f_rx[1]), 32'h62);
    frame(8'h84, 8'h5A, 8'h00, 2, 0);
    frame(8'h04, 8'h00, 8'h00, 2, 0);
    check("scratch_rw", 32'(f_rx[1]), 32'h5A);

    // Address wraps from 0x7F to 0x00; the second data byte writes keycode.
    frame(8'hFF, 8'h33, 8'h44, 3, 0);
    check("wrap_read_7f", 32'(f_rx[1]), 32'h00);
    check("wrap_read_00", 32'(f_rx[2]), 32'h04);
    check("wrap_keycode", 32'(keycode), 32'h44);

    frame(8'h80, 8'h77, 8'h00, 2, 5);
    check("abort_keycode_kept", 32'(keycode), 32'h44);
    frame(8'h80, 8'h04, 8'h00, 2, 0);
    check("after_abort_keycode", 32'(keycode), 32'h04);

    for (int n = 0; n < 40; n++) begin
      score = 10'($urandom);
      r = int'($urandom_range(0, 9));
      a = (r < 8) ? 7'(r) : ((r == 8) ? 7'h7F : 7'($urandom));
      f_tx[0] = {1'($urandom_range(0, 1)), a};
      f_len = 2 + int'($urandom_range(0, 3));
      for (int b = 1; b < f_len; b++) f_tx[b] = 8'($urandom);
      f_abort = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_frame();
    end

    // Reset during the third bit of a keycode data byte.
    SS_n = 1'b0;
    wait_clk(4);
    clock_bits(8'h80, 8, 1'b0, junk);
    clock_bits(8'hC3, 3, 1'b0, junk);
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_keycode", 32'(keycode), 32'h00);
    check("midrst_valid", 32'(keycode_valid), 32'h0);
    check("midrst_miso", 32'(MISO), 32'h0);
    check("midrst_miso_oe", 32'(MISO_oe), 32'h0);
    model_reset();
    SS_n = 1'b1;
    SCLK = 1'b0;
    wait_clk(3);
    Reset_n = 1'b1;
    wait_clk(4);
    frame(8'h80, 8'h1A, 8'h00, 2, 0);
    check("post_reset_keycode", 32'(keycode), 32'h1A);
    frame(8'h04, 8'h00, 8'h00, 2, 0);
    check("post_reset_scratch", 32'(f_rx[1]), 32'h00);

    // A frame already running when reset is released must be ignored.
    Reset_n = 1'b0;
    SS_n = 1'b0;
    model_reset();
    wait_clk(3);
    Reset_n = 1'b1;
    wait_clk(4);
    clock_bits(8'h80, 8, 1'b0, junk);
    clock_bits(8'h55, 8, 1'b0, junk);
    wait_clk(HALF);
    SS_n = 1'b1;
    wait_clk(HALF);
    check("ignored_frame_keycode", 32'(keycode), 32'h00);
    frame(8'h80, 8'h2B, 8'h00, 2, 0);
    check("after_ignored_keycode", 32'(keycode), 32'h2B);

    wait_clk(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
